// File: rtl/fcs_pkg.sv
// Shared definitions for the FCS path: CRC defaults and the engine state encoding.
// Used by the CRC engine, the FCS serializer and the frame-level top.
package fcs_pkg;

    localparam int GEN_WIDTH_DEFAULT = 17;
    localparam int REM_WIDTH_DEFAULT = GEN_WIDTH_DEFAULT - 1;

    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [15:0] CRC_SEED_DEFAULT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        SHIFT = 2'd2
    } fcs_state_t;

endpackage

// File: rtl/crc_lfsr_step.sv
// One MSB-first LFSR step of a CRC register; purely combinational so it can be
// shared with a receive-side checker.
module crc_lfsr_step #(
    parameter int                   REM_WIDTH = 16,
    parameter logic [REM_WIDTH-1:0] POLY      = 16'h1021
) (
    input  logic [REM_WIDTH-1:0] crc,
    input  logic                 data,
    output logic [REM_WIDTH-1:0] crc_next
);

    logic fb;

    assign fb       = data ^ crc[REM_WIDTH-1];
    assign crc_next = {crc[REM_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/fcs_crc_engine.sv
// Serial CRC engine: accumulates a frame while Data_Valid is high, then presents the
// remainder on FCS_result and holds Shift_enable until the serializer reports Shift_done.
module fcs_crc_engine
    import fcs_pkg::*;
#(
    parameter int                   GEN_WIDTH      = GEN_WIDTH_DEFAULT,
    parameter int                   REM_WIDTH      = GEN_WIDTH - 1,
    parameter logic [REM_WIDTH-1:0] POLY           = CRC16_CCITT_POLY,
    parameter logic [REM_WIDTH-1:0] SEED           = CRC_SEED_DEFAULT,
    parameter logic [REM_WIDTH-1:0] XOR_OUT        = '0,
    parameter int                   MAX_FRAME_BITS = 4096
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Data_In,
    input  logic                 Data_Valid,
    input  logic                 Shift_done,
    output logic [REM_WIDTH-1:0] FCS_result,
    output logic                 Shift_enable,
    output logic                 Busy,
    output logic                 Overrun,
    output logic                 Len_Error
);

    localparam int CNT_W = $clog2(MAX_FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FRAME_BITS);

    fcs_state_t           state_reg, state_next;
    logic [REM_WIDTH-1:0] crc_reg, crc_next, crc_stepped;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [REM_WIDTH-1:0] fcs_reg, fcs_next;
    logic                 se_reg, se_next;
    logic                 busy_reg, busy_next;
    logic                 overrun_reg, overrun_next;
    logic                 len_err_reg, len_err_next;

    crc_lfsr_step #(
        .REM_WIDTH (REM_WIDTH),
        .POLY      (POLY)
    ) u_step (
        .crc      (crc_reg),
        .data     (Data_In),
        .crc_next (crc_stepped)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg   <= IDLE;
            crc_reg     <= SEED;
            cnt_reg     <= '0;
            fcs_reg     <= '0;
            se_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            len_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            crc_reg     <= crc_next;
            cnt_reg     <= cnt_next;
            fcs_reg     <= fcs_next;
            se_reg      <= se_next;
            busy_reg    <= busy_next;
            overrun_reg <= overrun_next;
            len_err_reg <= len_err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (Data_Valid)  state_next = CALC;
            CALC:    if (!Data_Valid) state_next = SHIFT;
            SHIFT:   if (Shift_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bits arriving in SHIFT are never folded into the CRC; they only raise Overrun.
    always_comb begin
        crc_next     = crc_reg;
        cnt_next     = cnt_reg;
        fcs_next     = fcs_reg;
        se_next      = se_reg;
        len_err_next = len_err_reg;
        overrun_next = 1'b0;
        busy_next    = (state_next != IDLE);
        case (state_reg)
            IDLE: begin
                if (Data_Valid) begin
                    crc_next     = crc_stepped;
                    cnt_next     = CNT_W'(1);
                    len_err_next = 1'b0;
                end
            end
            CALC: begin
                if (Data_Valid) begin
                    crc_next = crc_stepped;
                    if (cnt_reg == CNT_MAX) begin
                        len_err_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end else begin
                    fcs_next = crc_reg ^ XOR_OUT;
                    se_next  = 1'b1;
                end
            end
            SHIFT: begin
                overrun_next = Data_Valid;
                if (Shift_done) begin
                    se_next  = 1'b0;
                    crc_next = SEED;
                    cnt_next = '0;
                end
            end
            default: begin
                crc_next = SEED;
                cnt_next = '0;
                se_next  = 1'b0;
            end
        endcase
    end

    assign FCS_result   = fcs_reg;
    assign Shift_enable = se_reg;
    assign Busy         = busy_reg;
    assign Overrun      = overrun_reg;
    assign Len_Error    = len_err_reg;

endmodule

// File: doc/fcs_crc_engine.md
Name: fcs_crc_engine

Overview:
- Serial CRC generator that computes the frame check sequence over an incoming serial frame.
- MSB-first LFSR per bit; ends at Data_Valid deassertion.
- Presents the REM_WIDTH-bit remainder on FCS_result and holds Shift_enable to the downstream FCS serializer until that stage reports Shift_done.
- Sits directly upstream of the FCS serializer.

Parameters:
- GEN_WIDTH, 17, generator polynomial width including implicit x^16 term.
- REM_WIDTH, GEN_WIDTH-1, remainder/FCS width.
- POLY, 16'h1021, generator low-order coefficients (x^16 term implicit).
- SEED, 16'hFFFF, CRC register preset at reset and at the start of every frame.
- XOR_OUT, 16'h0000, value XORed into the remainder when latched to FCS_result.
- MAX_FRAME_BITS, 4096, frame length limit in bits.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-low
- Data_In  in  1  serial frame bit
- Data_Valid  in  1  Data_In qualifier; contiguous high run = one frame
- Shift_done  in  1  downstream serializer finished shifting the FCS
- FCS_result  out  REM_WIDTH  latched remainder, stable while Shift_enable=1
- Shift_enable  out  1  request/hold to downstream serializer
- Busy  out  1  high in CALC or SHIFT
- Overrun  out  1  one-cycle pulse: Data_Valid=1 while in SHIFT (bit dropped)
- Len_Error  out  1  sticky: current/last frame exceeded MAX_FRAME_BITS; cleared at next frame start

Behaviour:
- All outputs are registered.
- Reset values: FCS_result=0, Shift_enable=0, Busy=0, Overrun=0, Len_Error=0, crc=SEED, bit counter=0, state=IDLE.
- LFSR step, per accepted bit:
  - fb = Data_In ^ crc[REM_WIDTH-1]
  - crc <= {crc[REM_WIDTH-2:0],1'b0} ^ (fb ? POLY : 0)
- FSM IDLE:
  - crc==SEED.
  - Data_Valid=1 -> process bit, bit counter=1, clear Len_Error, go CALC.
- FSM CALC:
  - Data_Valid=1 -> process bit, bit counter+1.
  - The bit counter saturates at MAX_FRAME_BITS. Any bit accepted at saturation sets Len_Error; the CRC still updates.
  - Data_Valid=0 -> FCS_result <= crc ^ XOR_OUT, Shift_enable <= 1, go SHIFT.
  - FCS_result is valid in the same cycle Shift_enable first reads 1. Latency: first idle cycle after the last bit, then 1 clock.
- FSM SHIFT:
  - Hold Shift_enable=1 and FCS_result constant.
  - Shift_done sampled 1 -> on that edge: Shift_enable <= 0, crc <= SEED, bit counter <= 0, go IDLE.
  - Shift_enable must stay high continuously; the downstream counter restarts if it drops early.
  - With the standard serializer, Shift_enable is high REM_WIDTH+2 cycles.
- Data_Valid=1 in SHIFT:
  - Bit dropped, Overrun pulses for 1 cycle, CRC unchanged.
  - Applies also when Shift_done arrives the same cycle; Shift_done wins and the state goes IDLE.
- Back-to-back frames: a new frame may start the cycle after leaving SHIFT (IDLE accepts the bit immediately).
- Shift_done while not in SHIFT: ignored.
- Reset mid-frame or mid-SHIFT: immediate return to reset values. Partial CRC discarded, Shift_enable drops asynchronously.
- Single-bit frame is legal and produces a normal FCS.

Decomposition:
- Shared package fcs_pkg holds:
  - GEN_WIDTH/REM_WIDTH defaults, CRC16_CCITT_POLY=16'h1021, CRC_SEED_DEFAULT=16'hFFFF
  - state encoding typedef {IDLE, CALC, SHIFT}
  - shared with the serializer and the frame-level top.
- One natural sub-module, crc_lfsr_step:
  - Combinational next-state of the CRC register for one bit.
  - Parameterised by REM_WIDTH/POLY; reusable by a receive-side checker.

Test Plan:
1. Reset: hold RST=0 with random inputs -> all outputs 0. Release -> IDLE, Busy=0.
2. Known vector, POLY=1021, SEED=FFFF, XOR_OUT=0:
   - stimulus: ASCII "123456789" MSB-first, 72 contiguous bits, Data_Valid high.
   - response: FCS_result=16'h29B1 with Shift_enable rising one clock after Data_Valid falls.
   - "A" (8'h41) -> 16'hB915.
3. Handshake:
   - stimulus: connect a model of the FCS serializer.
   - response: Shift_enable held until Shift_done observed, then drops next edge.
   - serial output from the serializer equals 16'h29B1 LSB-first.
   - Busy high through to IDLE.
4. Overrun/collision:
   - stimulus: Data_Valid=1 during SHIFT, including the cycle Shift_done=1.
   - response: Overrun one-cycle pulse per dropped bit; FCS_result unchanged; next frame CRC starts from SEED.
5. Back-to-back frames and length:
   - stimulus: second "123456789" frame starting the cycle after return to IDLE.
   - response: again 16'h29B1.
   - MAX_FRAME_BITS=8 with a 9-bit frame -> Len_Error=1 until the next frame starts.
6. Reset mid-operation:
   - stimulus: assert RST during CALC (bit 30) and during SHIFT.
   - response: Shift_enable drops immediately; a fresh "A" frame after release yields 16'hB915.
